// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared constants and counter-width helper for the raster timing generator
package video_timing_pkg;
  localparam logic CSYNC_XNOR = 1'b0;
  localparam logic CSYNC_AND  = 1'b1;
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/timing_axis_counter.sv
// timing_axis_counter: one raster axis (pixels or lines) with sync and blanking decode
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int TOTAL      = 448,
  parameter int SYNC_START = 320,
  parameter int SYNC_LEN   = 32,
  parameter int ACTIVE     = 256,
  localparam int W         = cnt_width(TOTAL)
) (
  input  logic         clk14,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync,
  output logic         blank
);
  logic [31:0] c;
  assign c     = 32'(cnt);
  assign wrap  = inc && c == TOTAL - 1;
  assign sync  = c >= SYNC_START && c < SYNC_START + SYNC_LEN;
  assign blank = c >= ACTIVE;
  always_ff @(posedge clk14)
    if (!rst_n || clr) cnt <= '0;
    else if (inc) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing source with pixel divider,
// h/v sync, blanking, composite sync and line/frame strobes
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int H_TOTAL     = 448,
  parameter int V_TOTAL     = 320,
  parameter int HSYNC_START = 320,
  parameter int HSYNC_LEN   = 32,
  parameter int VSYNC_START = 248,
  parameter int VSYNC_LEN   = 8,
  parameter int H_ACTIVE    = 256,
  parameter int V_ACTIVE    = 192
) (
  input  logic                          clk14,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          resync,
  input  logic                          csync_mode,
  output logic                          pix_ce,
  output logic [cnt_width(H_TOTAL)-1:0] hc,
  output logic [cnt_width(V_TOTAL)-1:0] vc,
  output logic                          hsync_n,
  output logic                          vsync_n,
  output logic                          csync_n,
  output logic                          hblank,
  output logic                          vblank,
  output logic                          line_start,
  output logic                          frame_start
);
  localparam int DW = cnt_width(CLK_DIV);
  logic [DW-1:0] div;
  logic h_wrap, v_wrap, hs, vs;
  if (CLK_DIV < 1 || H_TOTAL < 1 || V_TOTAL < 1 || HSYNC_LEN < 1 || VSYNC_LEN < 1 ||
      H_ACTIVE < 1 || V_ACTIVE < 1 || H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL ||
      HSYNC_START + HSYNC_LEN > H_TOTAL || VSYNC_START + VSYNC_LEN > V_TOTAL) begin : g_bad_geometry
    $error("video_timing_gen: invalid raster geometry");
  end
  // strobes are gated by reset and resync so a restart never emits a stray pixel or wrap
  assign pix_ce = rst_n && en && !resync && 32'(div) == CLK_DIV - 1;
  always_ff @(posedge clk14)
    if (!rst_n || resync) div <= '0;
    else if (en) div <= pix_ce ? '0 : div + 1'b1;
  timing_axis_counter #(
    .TOTAL(H_TOTAL), .SYNC_START(HSYNC_START), .SYNC_LEN(HSYNC_LEN), .ACTIVE(H_ACTIVE)
  ) u_h (
    .clk14(clk14), .rst_n(rst_n), .clr(resync), .inc(pix_ce),
    .cnt(hc), .wrap(h_wrap), .sync(hs), .blank(hblank)
  );
  timing_axis_counter #(
    .TOTAL(V_TOTAL), .SYNC_START(VSYNC_START), .SYNC_LEN(VSYNC_LEN), .ACTIVE(V_ACTIVE)
  ) u_v (
    .clk14(clk14), .rst_n(rst_n), .clr(resync), .inc(h_wrap),
    .cnt(vc), .wrap(v_wrap), .sync(vs), .blank(vblank)
  );
  always_ff @(posedge clk14)
    if (!rst_n) csync_n <= 1'b1;
    else if (pix_ce) csync_n <= (csync_mode == CSYNC_AND) ? ~(hs | vs) : ~(hs ^ vs);
  assign hsync_n     = ~hs;
  assign vsync_n     = ~vs;
  assign line_start  = h_wrap;
  assign frame_start = v_wrap;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for a default-geometry and a tiny-geometry timing generator
module tb_video_timing_gen;
  typedef struct {int cd, ht, vt, hss, hsl, vss, vsl, ha, va;} geo_t;
  typedef struct {int div, hc, vc; logic cs;} st_t;
  typedef struct {logic pce, hs_n, vs_n, cs_n, hb, vb, ls, fs; int hc, vc;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_en = 1'b0, a_rs = 1'b0, a_mode = 1'b0;
  logic b_en = 1'b0, b_rs = 1'b0, b_mode = 1'b0;
  logic a_pce, a_hs_n, a_vs_n, a_cs_n, a_hb, a_vb, a_ls, a_fs;
  logic b_pce, b_hs_n, b_vs_n, b_cs_n, b_hb, b_vb, b_ls, b_fs;
  logic [8:0] a_hc, a_vc;
  logic [2:0] b_hc;
  logic [1:0] b_vc;

  geo_t ga = '{2, 448, 320, 320, 32, 248, 8, 256, 192};
  geo_t gb = '{1, 8, 4, 6, 2, 3, 1, 5, 3};
  st_t sa, sb;
  exp_t qa[$], qb[$];
  int checks = 0, errors = 0, cyc = 0;
  int a_ls_prev = -1, a_pce_prev = -1, b_fs_prev = -1, a_hs_low = 0;

  always #5 clk = ~clk;

  video_timing_gen u_a (
    .clk14(clk), .rst_n(rst_n), .en(a_en), .resync(a_rs), .csync_mode(a_mode),
    .pix_ce(a_pce), .hc(a_hc), .vc(a_vc), .hsync_n(a_hs_n), .vsync_n(a_vs_n),
    .csync_n(a_cs_n), .hblank(a_hb), .vblank(a_vb), .line_start(a_ls), .frame_start(a_fs)
  );

  video_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(8), .V_TOTAL(4), .HSYNC_START(6), .HSYNC_LEN(2),
    .VSYNC_START(3), .VSYNC_LEN(1), .H_ACTIVE(5), .V_ACTIVE(3)
  ) u_b (
    .clk14(clk), .rst_n(rst_n), .en(b_en), .resync(b_rs), .csync_mode(b_mode),
    .pix_ce(b_pce), .hc(b_hc), .vc(b_vc), .hsync_n(b_hs_n), .vsync_n(b_vs_n),
    .csync_n(b_cs_n), .hblank(b_hb), .vblank(b_vb), .line_start(b_ls), .frame_start(b_fs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model_out(geo_t g, st_t s, logic rn, logic en, logic rs);
    exp_t e;
    e.pce  = rn && en && !rs && s.div == g.cd - 1;
    e.hs_n = !(s.hc >= g.hss && s.hc < g.hss + g.hsl);
    e.vs_n = !(s.vc >= g.vss && s.vc < g.vss + g.vsl);
    e.cs_n = s.cs;
    e.hb   = s.hc >= g.ha;
    e.vb   = s.vc >= g.va;
    e.ls   = e.pce && s.hc == g.ht - 1;
    e.fs   = e.ls && s.vc == g.vt - 1;
    e.hc   = s.hc;
    e.vc   = s.vc;
    return e;
  endfunction

  function automatic st_t model_next(geo_t g, st_t s, logic rn, logic en, logic rs, logic mode);
    st_t n;
    logic hs, vs;
    n  = s;
    hs = s.hc >= g.hss && s.hc < g.hss + g.hsl;
    vs = s.vc >= g.vss && s.vc < g.vss + g.vsl;
    if (!rn) n = '{0, 0, 0, 1'b1};
    else if (rs) begin
      n.div = 0;
      n.hc  = 0;
      n.vc  = 0;
    end else if (en) begin
      n.div = (s.div == g.cd - 1) ? 0 : s.div + 1;
      if (s.div == g.cd - 1) begin
        n.cs = mode ? !(hs || vs) : !(hs ^ vs);
        n.hc = (s.hc == g.ht - 1) ? 0 : s.hc + 1;
        if (s.hc == g.ht - 1) n.vc = (s.vc == g.vt - 1) ? 0 : s.vc + 1;
      end
    end
    return n;
  endfunction

  task automatic cmp(input string p, input exp_t e, input logic pce, input logic hs_n,
                     input logic vs_n, input logic cs_n, input logic hb, input logic vb,
                     input logic ls, input logic fs, input logic [31:0] hc, input logic [31:0] vc);
    check({p, ".pix_ce"}, 32'(pce), 32'(e.pce));
    check({p, ".hsync_n"}, 32'(hs_n), 32'(e.hs_n));
    check({p, ".vsync_n"}, 32'(vs_n), 32'(e.vs_n));
    check({p, ".csync_n"}, 32'(cs_n), 32'(e.cs_n));
    check({p, ".hblank"}, 32'(hb), 32'(e.hb));
    check({p, ".vblank"}, 32'(vb), 32'(e.vb));
    check({p, ".line_start"}, 32'(ls), 32'(e.ls));
    check({p, ".frame_start"}, 32'(fs), 32'(e.fs));
    check({p, ".hc"}, hc, e.hc);
    check({p, ".vc"}, vc, e.vc);
  endtask

  // one clock: push expectations for the driven inputs, compare, then advance the models
  task automatic step();
    exp_t ea, eb;
    qa.push_back(model_out(ga, sa, rst_n, a_en, a_rs));
    qb.push_back(model_out(gb, sb, rst_n, b_en, b_rs));
    #2;
    ea = qa.pop_front();
    eb = qb.pop_front();
    cmp("A", ea, a_pce, a_hs_n, a_vs_n, a_cs_n, a_hb, a_vb, a_ls, a_fs, 32'(a_hc), 32'(a_vc));
    cmp("B", eb, b_pce, b_hs_n, b_vs_n, b_cs_n, b_hb, b_vb, b_ls, b_fs, 32'(b_hc), 32'(b_vc));
    if (!rst_n || a_rs || !a_en) begin
      a_ls_prev  = -1;
      a_pce_prev = -1;
      a_hs_low   = 0;
    end
    if (!rst_n || b_rs || !b_en) b_fs_prev = -1;
    if (a_ls) begin
      if (a_ls_prev >= 0) check("A.line_period", cyc - a_ls_prev, 896);
      a_ls_prev = cyc;
    end
    if (a_pce) begin
      if (a_pce_prev >= 0) check("A.pix_period", cyc - a_pce_prev, 2);
      a_pce_prev = cyc;
    end
    if (b_fs) begin
      if (b_fs_prev >= 0) check("B.frame_period", cyc - b_fs_prev, 32);
      b_fs_prev = cyc;
    end
    if (!a_hs_n) a_hs_low++;
    else begin
      if (a_hs_low > 0) check("A.hsync_width", a_hs_low, 64);
      a_hs_low = 0;
    end
    @(posedge clk);
    sa = model_next(ga, sa, rst_n, a_en, a_rs, a_mode);
    sb = model_next(gb, sb, rst_n, b_en, b_rs, b_mode);
    cyc++;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    sa = '{0, 0, 0, 1'b1};
    sb = '{0, 0, 0, 1'b1};
    a_en = 1'b1;
    a_rs = 1'b1;
    repeat (3) step();
    check("rst.hc", 32'(a_hc), 0);
    check("rst.csync_n", 32'(a_cs_n), 1);
    rst_n = 1'b1;
    a_rs  = 1'b0;
    b_en  = 1'b1;
    for (int i = 0; i < 1000 && sa.hc != 100; i++) step();
    check("wait.hc100", 32'(a_hc), 100);
    a_en = 1'b0;
    repeat (100) step();
    check("freeze.hc", 32'(a_hc), 100);
    check("freeze.pix_ce", 32'(a_pce), 0);
    a_en = 1'b1;
    repeat (2) step();
    check("resume.hc", 32'(a_hc), 101);
    for (int i = 0; i < 1000 && !(sa.hc == 200 && sa.div == 1); i++) step();
    check("wait.hc200", 32'(a_hc), 200);
    a_rs = 1'b1;
    step();
    a_rs = 1'b0;
    check("resync.hc", 32'(a_hc), 0);
    check("resync.pix_ce", 32'(a_pce), 0);
    b_mode = 1'b1;
    for (int i = 0; i < 200 && !(sb.hc == 7 && sb.vc == 3); i++) step();
    check("wait.b_wrap", 32'(b_hc), 7);
    b_rs = 1'b1;
    #1;
    check("B.resync_fs", 32'(b_fs), 0);
    step();
    b_rs = 1'b0;
    check("B.resync_hc", 32'(b_hc), 0);
    check("B.resync_vc", 32'(b_vc), 0);
    for (int i = 0; i < 4000 && !(sa.hc == 200 && sa.vc == 2); i++) step();
    check("wait.vc2", 32'(a_vc), 2);
    rst_n = 1'b0;
    step();
    check("midrst.hc", 32'(a_hc), 0);
    check("midrst.vc", 32'(a_vc), 0);
    check("midrst.csync_n", 32'(a_cs_n), 1);
    check("midrst.line_start", 32'(a_ls), 0);
    rst_n  = 1'b1;
    a_mode = 1'b1;
    b_mode = 1'b0;
    repeat (2000) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
